stage1_feeder: RTL and testbench

- Producer-side driver for the stage-1 shift/add reduction stage.
- Collects NUM_INPUTS operand words from a serial valid/ready stream into the packed lane vector the stage consumes.
- Presents the frame in one of two modes:
  - Reduce mode: one beat, disable=0.
  - Pass-through mode: NUM_INPUTS beats, disable=1, count stepping 0..NUM_INPUTS-1 so each raw lane is selected in turn.
- Sits between the operand source and stage 1; generates the count/disable controls stage 1 expects.

---
 rtl/stage1_pkg.sv | 24 ++
 rtl/stage1_feeder_if.sv | 32 +++
 rtl/stage1_lane_loader.sv | 54 +++++
 rtl/stage1_feeder.sv | 105 ++++++++++
 tb/tb_stage1_feeder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/stage1_pkg.sv
// Shared types and sizing helpers for the stage-1 feeder slice.
// Latency: none (declarations only).
// Backpressure: n/a.
package stage1_pkg;

    localparam int DEF_NUM_INPUTS = 4;
    localparam int DEF_BIT_WIDTH  = 8;

    // Default lane type; modules re-declare lane_t locally from their own BIT_WIDTH
    localparam int LANE_W = DEF_BIT_WIDTH;
    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        EMIT_SUM  = 2'd1,
        EMIT_PASS = 2'd2
    } state_t;

    // Width of a lane index / stage-1 count for n lanes
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/stage1_feeder_if.sv
// Operand-stream and stage-1 frame signals of the feeder, bundled.
// Latency: none (wiring only).
// Backpressure: s_ready toward the source, m_ready from stage 1.
interface stage1_feeder_if import stage1_pkg::*; #(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int CNT_W      = cnt_w(NUM_INPUTS)
);
    logic                            s_valid;
    logic                            s_ready;
    logic [BIT_WIDTH-1:0]            s_data;
    logic                            cfg_disable;
    logic                            flush;
    logic                            m_valid;
    logic                            m_ready;
    logic [NUM_INPUTS*BIT_WIDTH-1:0] m_in;
    logic                            m_disable;
    logic [CNT_W-1:0]                m_count;
    logic                            busy;

    // Feeder side: drives frames toward stage 1
    modport master (
        input  s_valid, s_data, cfg_disable, flush, m_ready,
        output s_ready, m_valid, m_in, m_disable, m_count, busy
    );

    // Environment side: operand source plus stage-1 consumer
    modport slave (
        output s_valid, s_data, cfg_disable, flush, m_ready,
        input  s_ready, m_valid, m_in, m_disable, m_count, busy
    );
endinterface

// File: rtl/stage1_lane_loader.sv
// Serial-to-parallel lane bank: k-th accepted word of a frame lands in lane k.
// Latency: a write is visible on lanes the cycle after it is accepted.
// Backpressure: none internally; caller gates wr_en, flush beats a same-cycle write.
module stage1_lane_loader import stage1_pkg::*; #(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int CNT_W      = cnt_w(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic                            flush,
    input  logic [BIT_WIDTH-1:0]            wr_dat,
    output logic [NUM_INPUTS*BIT_WIDTH-1:0] lanes,
    output logic                            first_lane,
    output logic                            last_lane
);
    typedef logic [BIT_WIDTH-1:0] lane_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

    logic [CNT_W-1:0] fill_idx;
    logic             wr_go;
    lane_t            wr_lane;

    assign wr_go      = wr_en & ~flush;
    assign wr_lane    = wr_dat;
    assign first_lane = (fill_idx == '0);
    assign last_lane  = wr_go && (fill_idx == LAST_IDX);

    // Lane index: explicit wrap at NUM_INPUTS-1 so non-power-of-two counts work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_idx <= '0;
        end else if (flush) begin
            fill_idx <= '0;
        end else if (wr_go) begin
            fill_idx <= (fill_idx == LAST_IDX) ? '0 : fill_idx + CNT_W'(1);
        end
    end

    // Lane storage: only the addressed lane changes, others keep the previous frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= '0;
        end else if (wr_go) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                if (fill_idx == CNT_W'(k)) begin
                    lanes[k*BIT_WIDTH +: BIT_WIDTH] <= wr_lane;
                end
            end
        end
    end
endmodule

// File: rtl/stage1_feeder.sv
// Collects NUM_INPUTS operands and presents them to stage 1 as one sum beat or NUM_INPUTS pass beats.
// Latency: last word accepted in cycle t, m_valid high in cycle t+1.
// Backpressure: s_ready low while emitting; beats and controls held while m_ready is low.
module stage1_feeder import stage1_pkg::*; #(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int CNT_W      = cnt_w(NUM_INPUTS)
) (
    input  logic            clk,
    input  logic            rst_n,
    stage1_feeder_if.master bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

    state_t                          state;
    state_t                          state_nxt;
    logic                            mode;
    logic [CNT_W-1:0]                m_count_q;
    logic [NUM_INPUTS*BIT_WIDTH-1:0] lanes;
    logic                            in_fill;
    logic                            wr_en;
    logic                            flush_fill;
    logic                            first_lane;
    logic                            last_lane;

    assign in_fill    = (state == FILL);
    assign wr_en      = bus.s_valid & in_fill;
    assign flush_fill = bus.flush & in_fill;

    stage1_lane_loader #(
        .NUM_INPUTS (NUM_INPUTS),
        .BIT_WIDTH  (BIT_WIDTH),
        .CNT_W      (CNT_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .flush      (flush_fill),
        .wr_dat     (bus.s_data),
        .lanes      (lanes),
        .first_lane (first_lane),
        .last_lane  (last_lane)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame mode is captured with word 0; later cfg_disable changes wait for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else if (wr_en && !flush_fill && first_lane) begin
            mode <= bus.cfg_disable;
        end
    end

    // Pass-through lane selector: steps per accepted beat, explicit return to 0 after the last lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count_q <= '0;
        end else if (state == EMIT_PASS && bus.m_ready) begin
            m_count_q <= (m_count_q == LAST_CNT) ? '0 : m_count_q + CNT_W'(1);
        end
    end

    // Next state and frame-side outputs; NUM_INPUTS>=2 means mode is already latched at the last word
    always_comb begin
        state_nxt     = state;
        bus.s_ready   = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_disable = 1'b0;
        case (state)
            FILL: begin
                bus.s_ready = 1'b1;
                if (last_lane) begin
                    state_nxt = mode ? EMIT_PASS : EMIT_SUM;
                end
            end
            EMIT_SUM: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) begin
                    state_nxt = FILL;
                end
            end
            EMIT_PASS: begin
                bus.m_valid   = 1'b1;
                bus.m_disable = 1'b1;
                if (bus.m_ready && m_count_q == LAST_CNT) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign bus.m_in    = lanes;
    assign bus.m_count = m_count_q;
    assign bus.busy    = !(in_fill && first_lane);
endmodule

// File: tb/tb_stage1_feeder.sv
// Directed bench for stage1_feeder: reduce, pass-through with stalls, 3-lane build, flush, async reset.
// Latency: checks sampled 1ns after the rising edge.
// Backpressure: m_ready held low for stall cycles in pass-through.
module tb_stage1_feeder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    stage1_feeder_if #(.NUM_INPUTS(4), .BIT_WIDTH(8), .CNT_W(2)) bus4 ();
    stage1_feeder_if #(.NUM_INPUTS(3), .BIT_WIDTH(8), .CNT_W(2)) bus3 ();

    stage1_feeder #(.NUM_INPUTS(4), .BIT_WIDTH(8), .CNT_W(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    stage1_feeder #(.NUM_INPUTS(3), .BIT_WIDTH(8), .CNT_W(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int total = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] d, input logic cfg);
        bus4.s_valid     = 1'b1;
        bus4.s_data      = d;
        bus4.cfg_disable = cfg;
        tick();
        bus4.s_valid     = 1'b0;
    endtask

    task automatic push3(input logic [7:0] d, input logic cfg);
        bus3.s_valid     = 1'b1;
        bus3.s_data      = d;
        bus3.cfg_disable = cfg;
        tick();
        bus3.s_valid     = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus4.s_valid     = 1'b0;
        bus4.s_data      = '0;
        bus4.cfg_disable = 1'b0;
        bus4.flush       = 1'b0;
        bus4.m_ready     = 1'b0;
        bus3.s_valid     = 1'b0;
        bus3.s_data      = '0;
        bus3.cfg_disable = 1'b0;
        bus3.flush       = 1'b0;
        bus3.m_ready     = 1'b0;

        // Reset state
        #3;
        chk("rst_m_valid",   64'(bus4.m_valid),   64'h0);
        chk("rst_m_in",      64'(bus4.m_in),      64'h0);
        chk("rst_m_disable", 64'(bus4.m_disable), 64'h0);
        chk("rst_m_count",   64'(bus4.m_count),   64'h0);
        chk("rst_busy",      64'(bus4.busy),      64'h0);
        tick();
        rst_n = 1'b1;
        chk("rel_s_ready",   64'(bus4.s_ready),   64'h1);
        tick();

        // Reduce frame
        push4(8'h01, 1'b0);
        push4(8'h02, 1'b0);
        push4(8'h03, 1'b0);
        chk("red_not_early", 64'(bus4.m_valid),   64'h0);
        chk("red_busy_fill", 64'(bus4.busy),      64'h1);
        push4(8'h04, 1'b0);
        chk("red_m_valid",   64'(bus4.m_valid),   64'h1);
        chk("red_m_in",      64'(bus4.m_in),      64'h04030201);
        chk("red_m_disable", 64'(bus4.m_disable), 64'h0);
        chk("red_m_count",   64'(bus4.m_count),   64'h0);
        chk("red_s_ready",   64'(bus4.s_ready),   64'h0);
        bus4.m_ready = 1'b1;
        tick();
        bus4.m_ready = 1'b0;
        chk("red_done_vld",  64'(bus4.m_valid),   64'h0);
        chk("red_done_rdy",  64'(bus4.s_ready),   64'h1);
        chk("red_done_busy", 64'(bus4.busy),      64'h0);
        chk("red_hold_in",   64'(bus4.m_in),      64'h04030201);

        // Pass-through with stalls; cfg_disable drops mid-frame and must not matter
        push4(8'hA0, 1'b1);
        push4(8'hA1, 1'b1);
        push4(8'hA2, 1'b0);
        push4(8'hA3, 1'b0);
        chk("pass_m_valid",  64'(bus4.m_valid),   64'h1);
        chk("pass_mode",     64'(bus4.m_disable), 64'h1);
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 2; r++) begin
                chk("pass_stall_cnt", 64'(bus4.m_count),   64'(b));
                chk("pass_stall_vld", 64'(bus4.m_valid),   64'h1);
                chk("pass_stall_dis", 64'(bus4.m_disable), 64'h1);
                chk("pass_stall_in",  64'(bus4.m_in),      64'hA3A2A1A0);
                tick();
            end
            chk("pass_beat_cnt", 64'(bus4.m_count), 64'(b));
            bus4.m_ready = 1'b1;
            tick();
            bus4.m_ready = 1'b0;
        end
        chk("pass_end_vld", 64'(bus4.m_valid), 64'h0);
        chk("pass_end_cnt", 64'(bus4.m_count), 64'h0);
        chk("pass_end_rdy", 64'(bus4.s_ready), 64'h1);

        // Flush after two words; the word presented with flush is dropped
        push4(8'h55, 1'b1);
        push4(8'h66, 1'b1);
        bus4.flush   = 1'b1;
        bus4.s_valid = 1'b1;
        bus4.s_data  = 8'h77;
        tick();
        bus4.flush   = 1'b0;
        bus4.s_valid = 1'b0;
        chk("flush_busy",  64'(bus4.busy),    64'h0);
        chk("flush_vld",   64'(bus4.m_valid), 64'h0);
        push4(8'h10, 1'b0);
        push4(8'h20, 1'b0);
        push4(8'h30, 1'b0);
        chk("flush_not_early", 64'(bus4.m_valid), 64'h0);
        push4(8'h40, 1'b0);
        chk("flush_m_valid", 64'(bus4.m_valid),   64'h1);
        chk("flush_m_in",    64'(bus4.m_in),      64'h40302010);
        chk("flush_m_dis",   64'(bus4.m_disable), 64'h0);
        bus4.m_ready = 1'b1;
        tick();
        bus4.m_ready = 1'b0;
        chk("flush_done",    64'(bus4.m_valid),   64'h0);

        // Three lanes, pass-through: count 0,1,2 then back to FILL with 0
        push3(8'h11, 1'b1);
        push3(8'h22, 1'b1);
        push3(8'h33, 1'b1);
        chk("n3_m_valid", 64'(bus3.m_valid),   64'h1);
        chk("n3_m_in",    64'(bus3.m_in),      64'h332211);
        chk("n3_m_dis",   64'(bus3.m_disable), 64'h1);
        for (int b = 0; b < 3; b++) begin
            chk("n3_cnt", 64'(bus3.m_count), 64'(b));
            chk("n3_vld", 64'(bus3.m_valid), 64'h1);
            bus3.m_ready = 1'b1;
            tick();
            bus3.m_ready = 1'b0;
        end
        chk("n3_end_vld", 64'(bus3.m_valid), 64'h0);
        chk("n3_end_cnt", 64'(bus3.m_count), 64'h0);
        chk("n3_end_rdy", 64'(bus3.s_ready), 64'h1);

        // Async reset in the middle of a pass-through sequence
        push4(8'hB0, 1'b1);
        push4(8'hB1, 1'b1);
        push4(8'hB2, 1'b1);
        push4(8'hB3, 1'b1);
        bus4.m_ready = 1'b1;
        tick();
        tick();
        bus4.m_ready = 1'b0;
        chk("ar_cnt_before", 64'(bus4.m_count), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_m_valid", 64'(bus4.m_valid),   64'h0);
        chk("ar_m_count", 64'(bus4.m_count),   64'h0);
        chk("ar_m_dis",   64'(bus4.m_disable), 64'h0);
        chk("ar_m_in",    64'(bus4.m_in),      64'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_s_ready", 64'(bus4.s_ready), 64'h1);
        push4(8'h05, 1'b0);
        push4(8'h06, 1'b0);
        push4(8'h07, 1'b0);
        push4(8'h08, 1'b0);
        chk("ar_red_vld", 64'(bus4.m_valid),   64'h1);
        chk("ar_red_in",  64'(bus4.m_in),      64'h08070605);
        chk("ar_red_dis", 64'(bus4.m_disable), 64'h0);
        bus4.m_ready = 1'b1;
        tick();
        bus4.m_ready = 1'b0;
        chk("ar_red_done", 64'(bus4.m_valid), 64'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
